// File: rtl/lsb_pkg.sv
// Shared types and helpers for the in-order load/store queue.
// Op codes, entry states and the size/extension mapping used by the queue datapath.
package lsb_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    StEmpty,
    StWait,
    StReady,
    StExec,
    StStWait,
    StCommitted
  } entry_st_e;

  localparam int unsigned TAG_NULL = 0;

  function automatic logic [1:0] mem_size_of(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd2;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [31:0] ld_extend(input mem_op_e op, input logic [31:0] raw);
    case (op)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  return {24'd0, raw[7:0]};
      OP_LHU:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsb_entry_cap.sv
// Operand storage for one queue entry: captures base/data values from either CDB port,
// both while waiting and as a bypass on the cycle the entry is written.
module lsb_entry_cap
  import lsb_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             wr_en,
  input  logic             cap_en,
  input  logic [TAG_W-1:0] wr_qj,
  input  logic [TAG_W-1:0] wr_qk,
  input  logic [31:0]      wr_vj,
  input  logic [31:0]      wr_vk,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_val,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_val,
  output logic [TAG_W-1:0] qj,
  output logic [TAG_W-1:0] qk,
  output logic [31:0]      vj,
  output logic [31:0]      vk
);

  localparam logic [TAG_W-1:0] TagNull = TAG_W'(TAG_NULL);

  logic [TAG_W-1:0] qj_q, qj_d, qk_q, qk_d;
  logic [31:0]      vj_q, vj_d, vk_q, vk_d;

  function automatic logic [TAG_W+31:0] resolve(
    input logic [TAG_W-1:0] q, input logic [31:0] v,
    input logic c0v, input logic [TAG_W-1:0] c0t, input logic [31:0] c0d,
    input logic c1v, input logic [TAG_W-1:0] c1t, input logic [31:0] c1d
  );
    if (q != TagNull && c0v && q == c0t) return {TagNull, c0d};
    if (q != TagNull && c1v && q == c1t) return {TagNull, c1d};
    return {q, v};
  endfunction

  always_comb begin
    {qj_d, vj_d} = {qj_q, vj_q};
    {qk_d, vk_d} = {qk_q, vk_q};
    if (wr_en) begin
      {qj_d, vj_d} = resolve(wr_qj, wr_vj, cdb0_valid, cdb0_tag, cdb0_val,
                             cdb1_valid, cdb1_tag, cdb1_val);
      {qk_d, vk_d} = resolve(wr_qk, wr_vk, cdb0_valid, cdb0_tag, cdb0_val,
                             cdb1_valid, cdb1_tag, cdb1_val);
    end else if (cap_en) begin
      {qj_d, vj_d} = resolve(qj_q, vj_q, cdb0_valid, cdb0_tag, cdb0_val,
                             cdb1_valid, cdb1_tag, cdb1_val);
      {qk_d, vk_d} = resolve(qk_q, vk_q, cdb0_valid, cdb0_tag, cdb0_val,
                             cdb1_valid, cdb1_tag, cdb1_val);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      qj_q <= '0;
      qk_q <= '0;
      vj_q <= '0;
      vk_q <= '0;
    end else if (rdy_in) begin
      qj_q <= qj_d;
      qk_q <= qk_d;
      vj_q <= vj_d;
      vk_q <= vk_d;
    end
  end

  assign qj = qj_q;
  assign qk = qk_q;
  assign vj = vj_q;
  assign vk = vk_q;

endmodule

// File: rtl/lsb_queue_v2.sv
// In-order load/store queue: dispatch in, operand capture from two CDB ports, store resolve
// reporting, post-commit store drain, load execution with extension, and rollback.
module lsb_queue_v2
  import lsb_pkg::*;
#(
  parameter int unsigned LSB_DEPTH = 16,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic              issue_valid,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [3:0]        issue_op,
  input  logic [31:0]       issue_imm,
  input  logic [31:0]       issue_vj,
  input  logic [31:0]       issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb0_valid,
  input  logic [TAG_W-1:0]  cdb0_tag,
  input  logic [31:0]       cdb0_val,
  input  logic              cdb1_valid,
  input  logic [TAG_W-1:0]  cdb1_tag,
  input  logic [31:0]       cdb1_val,
  input  logic              commit_store,
  input  logic [TAG_W-1:0]  commit_tag,
  output logic              lsb_full,
  output logic              lsb_empty,
  output logic              st_rdy_valid,
  output logic [TAG_W-1:0]  st_rdy_tag,
  output logic              ld_bc_valid,
  output logic [TAG_W-1:0]  ld_bc_tag,
  output logic [31:0]       ld_bc_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned PTR_W = $clog2(LSB_DEPTH);
  localparam logic [TAG_W-1:0] TagNull = TAG_W'(TAG_NULL);

  typedef logic [PTR_W:0] ptr_t;

  entry_st_e        st_q  [LSB_DEPTH];
  entry_st_e        st_d  [LSB_DEPTH];
  logic [TAG_W-1:0] tag_q [LSB_DEPTH];
  mem_op_e          op_q  [LSB_DEPTH];
  logic [31:0]      imm_q [LSB_DEPTH];
  logic [TAG_W-1:0] qj_w  [LSB_DEPTH];
  logic [TAG_W-1:0] qk_w  [LSB_DEPTH];
  logic [31:0]      vj_w  [LSB_DEPTH];
  logic [31:0]      vk_w  [LSB_DEPTH];
  logic [LSB_DEPTH-1:0] wr_en;

  ptr_t head_q, head_d, tail_q, tail_d, count, kept;
  logic [PTR_W-1:0] head_idx, tail_idx, idx;
  logic mem_req_q, mem_req_d, discard_q, discard_d;
  logic st_rdy_valid_q, st_rdy_valid_d, ld_bc_valid_q, ld_bc_valid_d;
  logic [TAG_W-1:0] st_rdy_tag_q, st_rdy_tag_d, ld_bc_tag_q, ld_bc_tag_d;
  logic [31:0] ld_bc_val_q, ld_bc_val_d;
  logic issue_fire, pop, found_st, found_cm, head_store;
  mem_op_e issue_op_e;
  logic [TAG_W-1:0] issue_qk_eff;

  assign head_idx     = head_q[PTR_W-1:0];
  assign tail_idx     = tail_q[PTR_W-1:0];
  assign count        = tail_q - head_q;
  assign lsb_full     = (count == ptr_t'(LSB_DEPTH));
  assign lsb_empty    = (count == '0);
  assign head_store   = is_store(op_q[head_idx]);
  assign issue_op_e   = mem_op_e'(issue_op);
  assign issue_qk_eff = is_store(issue_op_e) ? issue_qk : TagNull;

  for (genvar g = 0; g < LSB_DEPTH; g++) begin : g_entry
    lsb_entry_cap #(.TAG_W(TAG_W)) u_cap (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rdy_in     (rdy_in),
      .wr_en      (wr_en[g]),
      .cap_en     (st_q[g] == StWait),
      .wr_qj      (issue_qj),
      .wr_qk      (issue_qk_eff),
      .wr_vj      (issue_vj),
      .wr_vk      (issue_vk),
      .cdb0_valid (cdb0_valid),
      .cdb0_tag   (cdb0_tag),
      .cdb0_val   (cdb0_val),
      .cdb1_valid (cdb1_valid),
      .cdb1_tag   (cdb1_tag),
      .cdb1_val   (cdb1_val),
      .qj         (qj_w[g]),
      .qk         (qk_w[g]),
      .vj         (vj_w[g]),
      .vk         (vk_w[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < LSB_DEPTH; i++) st_d[i] = st_q[i];
    head_d         = head_q;
    tail_d         = tail_q;
    mem_req_d      = mem_req_q;
    discard_d      = discard_q;
    st_rdy_valid_d = 1'b0;
    st_rdy_tag_d   = '0;
    ld_bc_valid_d  = 1'b0;
    ld_bc_tag_d    = '0;
    ld_bc_val_d    = '0;
    wr_en          = '0;
    issue_fire     = 1'b0;
    pop            = 1'b0;
    found_st       = 1'b0;
    found_cm       = 1'b0;
    kept           = '0;
    idx            = '0;

    for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
      if (st_q[i] == StWait && qj_w[i] == TagNull && qk_w[i] == TagNull) st_d[i] = StReady;
    end

    // Scan oldest-first so both store resolve and commit pick the oldest candidate.
    for (int unsigned k = 0; k < LSB_DEPTH; k++) begin
      idx = head_idx + PTR_W'(k);
      if (!found_st && st_q[idx] == StReady && is_store(op_q[idx])) begin
        found_st       = 1'b1;
        st_d[idx]      = StStWait;
        st_rdy_valid_d = 1'b1;
        st_rdy_tag_d   = tag_q[idx];
      end
      if (commit_store && !found_cm && st_q[idx] == StStWait && tag_q[idx] == commit_tag) begin
        found_cm  = 1'b1;
        st_d[idx] = StCommitted;
      end
    end

    if (!mem_req_q && !discard_q) begin
      if (st_q[head_idx] == StCommitted ||
          (st_q[head_idx] == StReady && !head_store && !roll_back)) begin
        st_d[head_idx] = StExec;
        mem_req_d      = 1'b1;
      end
    end

    if (mem_done) begin
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (mem_req_q) begin
        pop            = 1'b1;
        st_d[head_idx] = StEmpty;
        head_d         = head_q + ptr_t'(1);
        mem_req_d      = 1'b0;
        if (!head_store && !roll_back) begin
          ld_bc_valid_d = 1'b1;
          ld_bc_tag_d   = tag_q[head_idx];
          ld_bc_val_d   = ld_extend(op_q[head_idx], mem_rdata);
        end
      end
    end

    if (roll_back) begin
      // An in-flight load is abandoned; its completion pulse is still owed by memory.
      if (mem_req_q && !mem_done && !head_store) begin
        discard_d = 1'b1;
        mem_req_d = 1'b0;
      end
      for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
        if (st_d[i] == StCommitted || (st_d[i] == StExec && is_store(op_q[i]))) begin
          kept = kept + ptr_t'(1);
        end else begin
          st_d[i] = StEmpty;
        end
      end
      tail_d         = head_d + kept;
      st_rdy_valid_d = 1'b0;
      st_rdy_tag_d   = '0;
    end else if (issue_valid && (!lsb_full || pop)) begin
      issue_fire     = 1'b1;
      st_d[tail_idx] = StWait;
      wr_en[tail_idx] = 1'b1;
      tail_d         = tail_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < LSB_DEPTH; i++) begin
        st_q[i]  <= StEmpty;
        tag_q[i] <= '0;
        op_q[i]  <= OP_LB;
        imm_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      mem_req_q      <= 1'b0;
      discard_q      <= 1'b0;
      st_rdy_valid_q <= 1'b0;
      st_rdy_tag_q   <= '0;
      ld_bc_valid_q  <= 1'b0;
      ld_bc_tag_q    <= '0;
      ld_bc_val_q    <= '0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < LSB_DEPTH; i++) st_q[i] <= st_d[i];
      if (issue_fire) begin
        tag_q[tail_idx] <= issue_tag;
        op_q[tail_idx]  <= issue_op_e;
        imm_q[tail_idx] <= issue_imm;
      end
      head_q         <= head_d;
      tail_q         <= tail_d;
      mem_req_q      <= mem_req_d;
      discard_q      <= discard_d;
      st_rdy_valid_q <= st_rdy_valid_d;
      st_rdy_tag_q   <= st_rdy_tag_d;
      ld_bc_valid_q  <= ld_bc_valid_d;
      ld_bc_tag_q    <= ld_bc_tag_d;
      ld_bc_val_q    <= ld_bc_val_d;
    end
  end

  assign st_rdy_valid = st_rdy_valid_q;
  assign st_rdy_tag   = st_rdy_tag_q;
  assign ld_bc_valid  = ld_bc_valid_q;
  assign ld_bc_tag    = ld_bc_tag_q;
  assign ld_bc_val    = ld_bc_val_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_req_q && head_store;
  assign mem_addr     = mem_req_q ? ADDR_W'(vj_w[head_idx]) + ADDR_W'(imm_q[head_idx]) : '0;
  assign mem_wdata    = mem_we ? vk_w[head_idx] : '0;
  assign mem_size     = mem_req_q ? mem_size_of(op_q[head_idx]) : 2'd0;

endmodule

// File: tb/tb_lsb_queue_v2.sv
// Directed bench for lsb_queue_v2: load/store flow, bypass, fill/wrap and rollback cases.
module tb_lsb_queue_v2;
  import lsb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, roll_back, issue_valid;
  logic [4:0]  issue_tag, issue_qj, issue_qk;
  logic [3:0]  issue_op;
  logic [31:0] issue_imm, issue_vj, issue_vk;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_val, cdb1_val;
  logic        commit_store;
  logic [4:0]  commit_tag;
  logic        lsb_full, lsb_empty, st_rdy_valid, ld_bc_valid;
  logic [4:0]  st_rdy_tag, ld_bc_tag;
  logic [31:0] ld_bc_val, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;

  int n_checks = 0;
  int n_pass   = 0;

  lsb_queue_v2 #(.LSB_DEPTH(16), .TAG_W(5), .ADDR_W(32)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .roll_back    (roll_back),
    .issue_valid  (issue_valid),
    .issue_tag    (issue_tag),
    .issue_op     (issue_op),
    .issue_imm    (issue_imm),
    .issue_vj     (issue_vj),
    .issue_vk     (issue_vk),
    .issue_qj     (issue_qj),
    .issue_qk     (issue_qk),
    .cdb0_valid   (cdb0_valid),
    .cdb0_tag     (cdb0_tag),
    .cdb0_val     (cdb0_val),
    .cdb1_valid   (cdb1_valid),
    .cdb1_tag     (cdb1_tag),
    .cdb1_val     (cdb1_val),
    .commit_store (commit_store),
    .commit_tag   (commit_tag),
    .lsb_full     (lsb_full),
    .lsb_empty    (lsb_empty),
    .st_rdy_valid (st_rdy_valid),
    .st_rdy_tag   (st_rdy_tag),
    .ld_bc_valid  (ld_bc_valid),
    .ld_bc_tag    (ld_bc_tag),
    .ld_bc_val    (ld_bc_val),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_size     (mem_size),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(mem_req), 64'd1);
  endtask

  task automatic wait_st(input string name);
    int n = 0;
    while (st_rdy_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(st_rdy_valid), 64'd1);
  endtask

  task automatic issue(input logic [4:0] tag, input logic [3:0] op, input logic [31:0] vj,
                       input logic [31:0] imm, input logic [31:0] vk, input logic [4:0] qj,
                       input logic [4:0] qk);
    issue_valid = 1'b1;
    issue_tag   = tag;
    issue_op    = op;
    issue_vj    = vj;
    issue_imm   = imm;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic mem_finish(input logic [31:0] rdata);
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
  endtask

  logic [3:0]  ext_op   [3] = '{OP_LBU, OP_LH, OP_LHU};
  logic [31:0] ext_raw  [3] = '{32'h0000_0080, 32'h1234_8001, 32'h1234_8001};
  logic [31:0] ext_exp  [3] = '{32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
  logic [1:0]  ext_size [3] = '{2'd0, 2'd1, 2'd1};

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; issue_valid = 1'b0;
    issue_tag = '0; issue_op = '0; issue_imm = '0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0; cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_val = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_val = '0; commit_store = 1'b0; commit_tag = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst_empty", 64'(lsb_empty), 64'd1);
    check("rst_full", 64'(lsb_full), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_st_rdy", 64'(st_rdy_valid), 64'd0);
    check("rst_ld_bc", 64'(ld_bc_valid), 64'd0);
    rst_n_in = 1'b1;
    tick();

    // Plain LW
    issue(5'd1, OP_LW, 32'h100, 32'h4, 32'h0, 5'd0, 5'd0);
    check("lw_not_empty", 64'(lsb_empty), 64'd0);
    wait_req("lw_req");
    check("lw_addr", 64'(mem_addr), 64'h104);
    check("lw_size", 64'(mem_size), 64'd2);
    check("lw_we", 64'(mem_we), 64'd0);
    mem_finish(32'hDEAD_BEEF);
    check("lw_bc_valid", 64'(ld_bc_valid), 64'd1);
    check("lw_bc_tag", 64'(ld_bc_tag), 64'd1);
    check("lw_bc_val", 64'(ld_bc_val), 64'hDEAD_BEEF);
    check("lw_req_drop", 64'(mem_req), 64'd0);
    check("lw_empty", 64'(lsb_empty), 64'd1);
    tick();
    check("lw_bc_pulse", 64'(ld_bc_valid), 64'd0);

    // LB waiting on tag 3, resolved by cdb0
    issue(5'd2, OP_LB, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
    repeat (3) tick();
    check("lb_wait_noreq", 64'(mem_req), 64'd0);
    cdb0_valid = 1'b1; cdb0_tag = 5'd3; cdb0_val = 32'h200;
    tick();
    cdb0_valid = 1'b0;
    wait_req("lb_req");
    check("lb_addr", 64'(mem_addr), 64'h200);
    check("lb_size", 64'(mem_size), 64'd0);
    mem_finish(32'h0000_0080);
    check("lb_val", 64'(ld_bc_val), 64'hFFFF_FF80);
    check("lb_tag", 64'(ld_bc_tag), 64'd2);

    for (int i = 0; i < 3; i++) begin
      issue(5'(12 + i), ext_op[i], 32'h200, 32'(2 * i), 32'h0, 5'd0, 5'd0);
      wait_req($sformatf("ext%0d_req", i));
      check($sformatf("ext%0d_size", i), 64'(mem_size), 64'(ext_size[i]));
      check($sformatf("ext%0d_addr", i), 64'(mem_addr), 64'(32'h200 + 32'(2 * i)));
      mem_finish(ext_raw[i]);
      check($sformatf("ext%0d_val", i), 64'(ld_bc_val), 64'(ext_exp[i]));
      check($sformatf("ext%0d_tag", i), 64'(ld_bc_tag), 64'(12 + i));
    end

    // SW with store data bypassed from cdb1 in the issue cycle
    cdb1_valid = 1'b1; cdb1_tag = 5'd7; cdb1_val = 32'h1234_5678;
    issue(5'd5, OP_SW, 32'h300, 32'h8, 32'h0, 5'd0, 5'd7);
    cdb1_valid = 1'b0;
    wait_st("sw_st_rdy");
    check("sw_st_tag", 64'(st_rdy_tag), 64'd5);
    tick();
    check("sw_st_pulse", 64'(st_rdy_valid), 64'd0);
    repeat (3) tick();
    check("sw_no_req_precommit", 64'(mem_req), 64'd0);
    commit_store = 1'b1; commit_tag = 5'd5;
    tick();
    commit_store = 1'b0;
    wait_req("sw_req");
    check("sw_we", 64'(mem_we), 64'd1);
    check("sw_addr", 64'(mem_addr), 64'h308);
    check("sw_wdata", 64'(mem_wdata), 64'h1234_5678);
    check("sw_size", 64'(mem_size), 64'd2);
    mem_finish(32'h0);
    check("sw_no_bc", 64'(ld_bc_valid), 64'd0);
    check("sw_empty", 64'(lsb_empty), 64'd1);

    // Fill to 16, then pop and issue in the same cycle
    issue(5'd10, OP_LW, 32'h40, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 15; i++) issue(5'(11 + i), OP_LW, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0);
    check("fill_full", 64'(lsb_full), 64'd1);
    check("fill_req", 64'(mem_req), 64'd1);
    issue_valid = 1'b1; issue_tag = 5'd27; issue_op = OP_LW; issue_qj = 5'd9; issue_qk = 5'd0;
    mem_done = 1'b1; mem_rdata = 32'h55;
    tick();
    issue_valid = 1'b0; mem_done = 1'b0;
    check("fill_pop_issue_full", 64'(lsb_full), 64'd1);
    check("fill_bc_tag", 64'(ld_bc_tag), 64'd10);
    check("fill_bc_val", 64'(ld_bc_val), 64'h55);
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    check("fill_rb_empty", 64'(lsb_empty), 64'd1);
    check("fill_rb_notfull", 64'(lsb_full), 64'd0);
    cdb0_valid = 1'b1; cdb0_tag = 5'd9; cdb0_val = 32'h0;
    tick();
    cdb0_valid = 1'b0;
    repeat (3) tick();
    check("fill_rb_flushed", 64'(mem_req), 64'd0);

    // Committed store in flight survives rollback; younger loads do not
    issue(5'd6, OP_SW, 32'h600, 32'h0, 32'hA5A5_A5A5, 5'd0, 5'd0);
    wait_st("rb_st_rdy");
    check("rb_st_tag", 64'(st_rdy_tag), 64'd6);
    for (int i = 0; i < 3; i++) issue(5'(16 + i), OP_LW, 32'h700, 32'h0, 32'h0, 5'd0, 5'd0);
    check("rb_no_req", 64'(mem_req), 64'd0);
    commit_store = 1'b1; commit_tag = 5'd6;
    tick();
    commit_store = 1'b0;
    wait_req("rb_st_req");
    check("rb_st_we", 64'(mem_we), 64'd1);
    check("rb_st_wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    check("rb_st_continues", 64'(mem_req), 64'd1);
    check("rb_st_kept", 64'(lsb_empty), 64'd0);
    mem_finish(32'h0);
    check("rb_st_done_empty", 64'(lsb_empty), 64'd1);
    check("rb_st_no_bc", 64'(ld_bc_valid), 64'd0);
    repeat (4) tick();
    check("rb_loads_gone", 64'(mem_req), 64'd0);
    check("rb_loads_no_bc", 64'(ld_bc_valid), 64'd0);

    // Rollback of an executing load: its late completion is discarded
    issue(5'd8, OP_LW, 32'h400, 32'h0, 32'h0, 5'd0, 5'd0);
    wait_req("disc_req");
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    check("disc_req_drop", 64'(mem_req), 64'd0);
    mem_finish(32'h11);
    check("disc_no_bc", 64'(ld_bc_valid), 64'd0);
    check("disc_empty", 64'(lsb_empty), 64'd1);
    issue(5'd9, OP_LW, 32'h500, 32'h10, 32'h0, 5'd0, 5'd0);
    wait_req("post_req");
    check("post_addr", 64'(mem_addr), 64'h510);
    mem_finish(32'hCAFE_F00D);
    check("post_bc_valid", 64'(ld_bc_valid), 64'd1);
    check("post_bc_tag", 64'(ld_bc_tag), 64'd9);
    check("post_bc_val", 64'(ld_bc_val), 64'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
